// File: rtl/fifo_stack_ctrl_pkg.sv
// Shared encodings for the fifo_stack controller: FSM states, last-op tags, requester indices.
// Optional build macro FIFO_STACK_CTRL_FIXED_PRIO_EN (see fifo_stack_ctrl_arb) changes arbitration only.
package fifo_stack_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SAVE  = 3'd1,
    ST_POP   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/fifo_stack_ctrl_arb.sv
// Two-way write grant: round-robin by default, A-over-B fixed priority when
// FIFO_STACK_CTRL_FIXED_PRIO_EN is defined.
module fifo_stack_ctrl_arb
  import fifo_stack_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef FIFO_STACK_CTRL_FIXED_PRIO_EN

  logic unused_fixed;
  assign unused_fixed = ^{clk, rst, advance};

  always_comb begin
    grant        = '0;
    grant[REQ_A] = req[REQ_A];
    grant[REQ_B] = req[REQ_B] & ~req[REQ_A];
  end

`else

  logic rr_ptr_reg;

  always_comb begin
    grant = req;
    if (req[REQ_A] && req[REQ_B]) begin
      grant         = '0;
      grant[rr_ptr_reg] = 1'b1;
    end
  end

  // Pointer always moves to the side that was not just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= REQ_A;
    end else if (advance && (|grant)) begin
      rr_ptr_reg <= grant[REQ_A] ? REQ_B : REQ_A;
    end
  end

`endif

endmodule

// File: rtl/fifo_stack_ctrl.sv
// Sequencer in front of one fifo_stack: arbitrates A/B writes, drains into a
// valid/ready register, issues one registered save/pop/reset pulse at a time.
module fifo_stack_ctrl
  import fifo_stack_ctrl_pkg::*;
#(
  parameter int STACK_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STACK_WIDTH-1:0] A_DATA,
  input  logic                   A_req,
  output logic                   A_ack,
  input  logic [STACK_WIDTH-1:0] B_DATA,
  input  logic                   B_req,
  output logic                   B_ack,
  output logic [STACK_WIDTH-1:0] RD_DATA,
  output logic                   RD_valid,
  input  logic                   RD_ready,
  input  logic                   flush,
  output logic [STACK_WIDTH-1:0] F_I_DATA,
  output logic                   F_save,
  output logic                   F_pop,
  output logic                   F_reset,
  input  logic [STACK_WIDTH-1:0] F_O_DATA,
  input  logic                   F_full,
  input  logic                   F_empty,
  input  logic                   F_busy
);

  state_e                 state_reg, state_next;
  op_e                    last_op_reg, last_op_next;
  logic                   rd_valid_reg, rd_valid_next;
  logic [STACK_WIDTH-1:0] rd_data_reg, rd_data_next;
  logic [STACK_WIDTH-1:0] i_data_reg, i_data_next;
  logic                   save_reg, save_next;
  logic                   pop_reg, pop_next;
  logic                   reset_reg, reset_next;
  logic                   a_ack_reg, a_ack_next;
  logic                   b_ack_reg, b_ack_next;

  logic [1:0] req_vec;
  logic [1:0] grant;
  logic       advance;
  logic       rd_ok, wr_ok, do_rd, do_wr;

  assign req_vec = {B_req, A_req};

  fifo_stack_ctrl_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_vec),
    .advance (advance),
    .grant   (grant)
  );

  assign rd_ok = ~F_empty & ~rd_valid_reg & ~F_busy;
  assign wr_ok = (A_req | B_req) & ~F_full & ~F_busy;
  // On a tie, alternate with whatever was done last.
  assign do_rd = rd_ok & (~wr_ok | (last_op_reg == OP_WRITE));
  assign do_wr = wr_ok & ~do_rd;

  always_comb begin
    state_next    = state_reg;
    last_op_next  = last_op_reg;
    rd_valid_next = rd_valid_reg;
    rd_data_next  = rd_data_reg;
    i_data_next   = i_data_reg;
    save_next     = 1'b0;
    pop_next      = 1'b0;
    reset_next    = 1'b0;
    a_ack_next    = 1'b0;
    b_ack_next    = 1'b0;
    advance       = 1'b0;

    if (rd_valid_reg && RD_ready) begin
      rd_valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (flush) begin
          state_next    = ST_FLUSH;
          reset_next    = 1'b1;
          rd_valid_next = 1'b0;
        end else if (do_wr) begin
          state_next   = ST_SAVE;
          save_next    = 1'b1;
          i_data_next  = grant[REQ_A] ? A_DATA : B_DATA;
          a_ack_next   = grant[REQ_A];
          b_ack_next   = grant[REQ_B];
          last_op_next = OP_WRITE;
          advance      = 1'b1;
        end else if (do_rd) begin
          // Head row is captured on the same edge the pop is issued.
          state_next    = ST_POP;
          pop_next      = 1'b1;
          rd_data_next  = F_O_DATA;
          rd_valid_next = 1'b1;
          last_op_next  = OP_READ;
        end
      end
      ST_SAVE, ST_POP, ST_FLUSH: state_next = ST_WAIT;
      ST_WAIT: if (!F_busy) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      last_op_reg  <= OP_WRITE;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      i_data_reg   <= '0;
      save_reg     <= 1'b0;
      pop_reg      <= 1'b0;
      reset_reg    <= 1'b0;
      a_ack_reg    <= 1'b0;
      b_ack_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_op_reg  <= last_op_next;
      rd_valid_reg <= rd_valid_next;
      rd_data_reg  <= rd_data_next;
      i_data_reg   <= i_data_next;
      save_reg     <= save_next;
      pop_reg      <= pop_next;
      reset_reg    <= reset_next;
      a_ack_reg    <= a_ack_next;
      b_ack_reg    <= b_ack_next;
    end
  end

  assign A_ack    = a_ack_reg;
  assign B_ack    = b_ack_reg;
  assign RD_DATA  = rd_data_reg;
  assign RD_valid = rd_valid_reg;
  assign F_I_DATA = i_data_reg;
  assign F_save   = save_reg;
  assign F_pop    = pop_reg;
  // Reset also clears the stack even if it lands mid-operation.
  assign F_reset  = reset_reg | rst;

endmodule

// File: tb/tb_fifo_stack_ctrl.sv
// Directed table-driven bench for fifo_stack_ctrl; the stack flags are driven per vector.
module tb_fifo_stack_ctrl;

  localparam int W = 8;
`ifdef FIFO_STACK_CTRL_FIXED_PRIO_EN
  localparam logic FX = 1'b1;
`else
  localparam logic FX = 1'b0;
`endif
  // Expected grant on an A/B tie at the table rows where round-robin picks B.
  localparam logic       TA = FX;
  localparam logic       TB = ~FX;
  localparam logic [7:0] TD = FX ? 8'h11 : 8'h22;

  logic         clk = 1'b0;
  logic         rst, A_req, B_req, RD_ready, flush, F_full, F_empty, F_busy;
  logic [W-1:0] A_DATA, B_DATA, F_O_DATA;
  logic         A_ack, B_ack, RD_valid, F_save, F_pop, F_reset;
  logic [W-1:0] RD_DATA, F_I_DATA;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_stack_ctrl #(.STACK_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .A_DATA(A_DATA), .A_req(A_req), .A_ack(A_ack),
    .B_DATA(B_DATA), .B_req(B_req), .B_ack(B_ack),
    .RD_DATA(RD_DATA), .RD_valid(RD_valid), .RD_ready(RD_ready),
    .flush(flush),
    .F_I_DATA(F_I_DATA), .F_save(F_save), .F_pop(F_pop), .F_reset(F_reset),
    .F_O_DATA(F_O_DATA), .F_full(F_full), .F_empty(F_empty), .F_busy(F_busy)
  );

  typedef struct {
    logic       rst, ar;
    logic [7:0] ad;
    logic       br;
    logic [7:0] bd;
    logic       rdy, fl;
    logic [7:0] od;
    logic       full, empty, busy;
    logic [21:0] exp; // {A_ack,B_ack,F_save,F_pop,F_reset,F_I_DATA,RD_valid,RD_DATA}
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst_i, input logic ar, input logic [7:0] ad,
                   input logic br, input logic [7:0] bd, input logic rdy,
                   input logic fl, input logic [7:0] od, input logic full,
                   input logic empty, input logic busy,
                   input logic aack, input logic back, input logic save,
                   input logic pop, input logic frst, input logic [7:0] idata,
                   input logic rdv, input logic [7:0] rdd);
    vec_t t;
    t.rst = rst_i; t.ar = ar; t.ad = ad; t.br = br; t.bd = bd; t.rdy = rdy;
    t.fl = fl; t.od = od; t.full = full; t.empty = empty; t.busy = busy;
    t.exp = {aack, back, save, pop, frst, idata, rdv, rdd};
    vecs.push_back(t);
  endtask

  function automatic logic [21:0] actual();
    return {A_ack, B_ack, F_save, F_pop, F_reset, F_I_DATA, RD_valid, RD_DATA};
  endfunction

  task automatic apply(input vec_t t);
    rst = t.rst; A_req = t.ar; A_DATA = t.ad; B_req = t.br; B_DATA = t.bd;
    RD_ready = t.rdy; flush = t.fl; F_O_DATA = t.od;
    F_full = t.full; F_empty = t.empty; F_busy = t.busy;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin
    int got;
    int saves;
    // rst ar ad    br bd    rdy fl od    full empty busy | aack back save pop frst idata rdv rdd
    v(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0,  0, 0, 0, 0, 1, 8'h00, 0, 8'h00); // 0 reset, stack full
    v(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0,  0, 0, 0, 0, 1, 8'h00, 0, 8'h00);
    v(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h00, 0, 8'h00); // 2 idle
    v(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    v(0, 1, 8'h5A, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0,  1, 0, 1, 0, 0, 8'h5A, 0, 8'h00); // 4 save A
    v(0, 0, 8'h5A, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h5A, 0, 8'h00);
    v(0, 0, 8'h5A, 0, 8'h00, 0, 0, 8'h5A, 0, 0, 0,  0, 0, 0, 0, 0, 8'h5A, 0, 8'h00);
    v(0, 0, 8'h5A, 0, 8'h00, 0, 0, 8'h5A, 0, 0, 0,  0, 0, 0, 1, 0, 8'h5A, 1, 8'h5A); // 7 pop
    v(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h5A, 1, 8'h5A);
    v(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h5A, 1, 8'h5A);
    v(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h5A, 0, 8'h5A); // 10 handshake
    v(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h5A, 0, 8'h5A);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 0, 1, 0, TA,TB, 1, 0, 0, TD,    0, 8'h5A); // 12 tie
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, TD,    0, 8'h5A);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, TD,    0, 8'h5A);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 0, 1, 0,  1, 0, 1, 0, 0, 8'h11, 0, 8'h5A); // 15
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h11, 0, 8'h5A);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h11, 0, 8'h5A);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 1, 1, 0,  0, 0, 0, 0, 0, 8'h11, 0, 8'h5A); // 18 full
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 1, 1, 0,  0, 0, 0, 0, 0, 8'h11, 0, 8'h5A);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h33, 1, 0, 0,  0, 0, 0, 1, 0, 8'h11, 1, 8'h33); // 20 read while full
    v(0, 1, 8'h11, 1, 8'h22, 1, 0, 8'h44, 0, 0, 0,  0, 0, 0, 0, 0, 8'h11, 0, 8'h33);
    v(0, 1, 8'h11, 1, 8'h22, 1, 0, 8'h44, 0, 0, 0,  0, 0, 0, 0, 0, 8'h11, 0, 8'h33);
    v(0, 1, 8'h11, 1, 8'h22, 1, 0, 8'h44, 0, 0, 0, TA,TB, 1, 0, 0, TD,    0, 8'h33); // 23 write after read
    v(0, 1, 8'h11, 1, 8'h22, 1, 0, 8'h44, 0, 0, 0,  0, 0, 0, 0, 0, TD,    0, 8'h33);
    v(0, 1, 8'h11, 1, 8'h22, 1, 0, 8'h44, 0, 0, 0,  0, 0, 0, 0, 0, TD,    0, 8'h33);
    v(0, 1, 8'h11, 1, 8'h22, 1, 0, 8'h44, 0, 0, 0,  0, 0, 0, 1, 0, TD,    1, 8'h44); // 26 read after write
    v(0, 1, 8'h11, 1, 8'h22, 1, 0, 8'h44, 0, 0, 0,  0, 0, 0, 0, 0, TD,    0, 8'h44);
    v(0, 1, 8'h11, 1, 8'h22, 1, 0, 8'h44, 0, 0, 0,  0, 0, 0, 0, 0, TD,    0, 8'h44);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h55, 0, 0, 0,  1, 0, 1, 0, 0, 8'h11, 0, 8'h44); // 29
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h55, 0, 0, 1,  0, 0, 0, 0, 0, 8'h11, 0, 8'h44); // 30 busy
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h55, 0, 0, 1,  0, 0, 0, 0, 0, 8'h11, 0, 8'h44);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h55, 0, 0, 1,  0, 0, 0, 0, 0, 8'h11, 0, 8'h44);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h55, 0, 0, 1,  0, 0, 0, 0, 0, 8'h11, 0, 8'h44);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h55, 0, 0, 1,  0, 0, 0, 0, 0, 8'h11, 0, 8'h44);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h55, 0, 0, 0,  0, 0, 0, 0, 0, 8'h11, 0, 8'h44); // 35 busy falls
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h55, 0, 0, 0,  0, 0, 0, 1, 0, 8'h11, 1, 8'h55);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h55, 0, 0, 0,  0, 0, 0, 0, 0, 8'h11, 1, 8'h55);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h55, 0, 0, 0,  0, 0, 0, 0, 0, 8'h11, 1, 8'h55);
    v(0, 1, 8'h11, 1, 8'h22, 0, 1, 8'h55, 0, 0, 0,  0, 0, 0, 0, 1, 8'h11, 0, 8'h55); // 39 flush
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h11, 0, 8'h55);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h11, 0, 8'h55);
    v(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 0, 1, 0, TA,TB, 1, 0, 0, TD,    0, 8'h55); // 42 served after flush
    v(0, 0, 8'h11, 0, 8'h22, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, TD,    0, 8'h55);
    v(0, 0, 8'h11, 0, 8'h22, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, TD,    0, 8'h55);
    v(0, 0, 8'h11, 0, 8'h22, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, TD,    0, 8'h55);
    v(0, 1, 8'h11, 0, 8'h22, 0, 0, 8'h00, 0, 1, 0,  1, 0, 1, 0, 0, 8'h11, 0, 8'h55); // 46
    v(1, 0, 8'h11, 0, 8'h22, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 1, 8'h00, 0, 8'h00); // 47 reset mid-op
    v(0, 0, 8'h11, 0, 8'h22, 0, 0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 0, 8'h00, 0, 8'h00);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {10'd0, actual()}, {10'd0, vecs[i].exp});
      $display("vec %0d: ack=%b%b save=%b pop=%b reset=%b idata=%h rdv=%b rdd=%h",
               i, A_ack, B_ack, F_save, F_pop, F_reset, F_I_DATA, RD_valid, RD_DATA);
    end

    // Lone B request after reset: bounded wait for its save.
    B_req = 1'b1; B_DATA = 8'h77; F_empty = 1'b1; F_full = 1'b0;
    got = 0;
    for (int c = 0; c < 8 && got == 0; c++) begin
      @(posedge clk);
      #1;
      if (F_save) got = c + 1;
    end
    check("b_save_latency", got, 1);
    check("b_save_ack", {A_ack, B_ack, F_I_DATA}, {1'b0, 1'b1, 8'h77});
    $display("seq b_only: latency=%0d ack=%b%b idata=%h", got, A_ack, B_ack, F_I_DATA);
    B_req = 1'b0;
    repeat (3) @(posedge clk);

    // Continuous A requests with no busy: one save every three cycles.
    #1;
    A_req = 1'b1; A_DATA = 8'h3C;
    saves = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (F_save) saves++;
    end
    check("throughput_saves", saves, 4);
    $display("seq throughput: saves=%0d in 12 cycles", saves);
    A_req = 1'b0;
    @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stack_ctrl.md
Name: fifo_stack_ctrl

Overview:
- Sequencer and arbiter in front of one fifo_stack instance in the USB3300 parser path.
- Arbitrates writes from two requesters (A: parser data, B: status/marker bytes) into the stack.
- Drains the stack into a registered valid/ready output for the downstream consumer (UART TX).
- Issues all FIFO_save/FIFO_pop/FIFO_reset pulses, one command at a time, and honours the stack's full/empty/busy flags.

Parameters:
- STACK_WIDTH, 8, data width; must match the controlled stack.

Ports:
- clk  in  1  master clock
- rst  in  1  synchronous, active-high reset
- A_DATA  in  STACK_WIDTH  requester A write data
- A_req  in  1  requester A write request; held with A_DATA until A_ack
- A_ack  out  1  one-cycle pulse: A_DATA accepted
- B_DATA  in  STACK_WIDTH  requester B write data
- B_req  in  1  requester B write request
- B_ack  out  1  one-cycle pulse: B_DATA accepted
- RD_DATA  out  STACK_WIDTH  drained word
- RD_valid  out  1  RD_DATA holds a word
- RD_ready  in  1  consumer accepts RD_DATA when RD_valid & RD_ready
- flush  in  1  request a stack reset; level, sampled in IDLE
- F_I_DATA  out  STACK_WIDTH  to stack I_DATA
- F_save  out  1  to stack FIFO_save
- F_pop  out  1  to stack FIFO_pop
- F_reset  out  1  to stack FIFO_reset
- F_O_DATA  in  STACK_WIDTH  from stack O_DATA (head row)
- F_full  in  1  from stack FIFO_full
- F_empty  in  1  from stack FIFO_empty
- F_busy  in  1  from stack FIFO_busy

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; rr_ptr=A; last_op=WRITE.
  - RD_valid=0, RD_DATA=0, A_ack=B_ack=0, F_save=F_pop=0, F_I_DATA=0.
  - F_reset is driven combinationally high while rst=1, so reset mid-operation also clears the stack.
- State machine (IDLE, SAVE, POP, WAIT, FLUSH). All F_* commands are registered, one-cycle pulses, and at most one is asserted per cycle.
- IDLE decision, priority order:
  - flush=1 goes to FLUSH.
  - Otherwise rd_ok = !F_empty & !RD_valid & !F_busy, and wr_ok = (A_req|B_req) & !F_full & !F_busy.
  - If both rd_ok and wr_ok: take the op opposite to last_op.
  - If only one is true: take that one. If neither: stay in IDLE.
- SAVE (1 cycle):
  - F_save=1 and F_I_DATA = data of the granted requester.
  - The matching ack pulses this same cycle.
  - last_op=WRITE; goes to WAIT.
- Grant: round-robin. If both requesters are active, grant rr_ptr's side; after any grant, rr_ptr points to the other side.
- POP (1 cycle):
  - RD_DATA <= F_O_DATA is captured before the pop takes effect, and RD_valid <= 1.
  - F_pop=1; last_op=READ; goes to WAIT.
- WAIT: minimum 1 cycle, then stays while F_busy=1. Goes to IDLE on F_busy=0.
- FLUSH (1 cycle):
  - F_reset=1 and RD_valid <= 0; goes to WAIT.
  - No acks are issued during flush; pending requests are served afterwards.
- RD handshake: when RD_valid & RD_ready, RD_valid clears next cycle. Independent of FSM state except FLUSH, which wins.
- Boundaries:
  - F_full blocks writes (no ack, requester stalls) but reads still proceed.
  - F_empty blocks reads.
  - A req deasserted before ack is legal; it is simply not granted.
- Throughput: at most one stack op per 3 cycles (cmd, WAIT, IDLE) when F_busy never asserts.

Optional Feature:
- FIFO_STACK_CTRL_FIXED_PRIO_EN
  - Defined: requester A always wins over B and rr_ptr is removed. B can starve; this is intended for latency-critical parser data.
  - Undefined: round-robin as specified above.

Decomposition:
- Shared package/header: FSM state encodings (IDLE, SAVE, POP, WAIT, FLUSH), the op encodings for last_op (READ/WRITE), and the requester index constants for A/B.
- One natural sub-module, fifo_stack_ctrl_arb: the 2-way round-robin/fixed grant logic (req[1:0], advance, grant[1:0]). The FSM and RD register stay in the top.

Test Plan:
- Reset and idle: hold rst 2 cycles with the stack full → F_reset=1 during rst; afterwards RD_valid=0, no F_* pulses while both reqs are low and F_empty=1.
- Single write then drain:
  - A_req=1 with A_DATA=0x5A → A_ack pulses with F_save=1 and F_I_DATA=0x5A.
  - The stack then reads back 0x5A → RD_valid=1, RD_DATA=0x5A, exactly one F_pop.
- Round-robin: A and B request continuously (A=0x11, B=0x22), RD_ready=0 → save order 0x11,0x22,0x11,0x22... until F_full. Then no ack, with reqs held stable.
- Read/write alternation: stack holds 3 words, A requests continuously, RD_ready=1 → F_save and F_pop alternate; drained order matches stack order.
- Busy stall: F_busy forced high for 5 cycles after an F_save → no new F_* pulse until F_busy falls, then the next command 1 cycle later.
- Flush mid-stream: RD_valid=1 and stack non-empty, pulse flush → F_reset one cycle, RD_valid=0, no ack that cycle. With FIXED_PRIO_EN, A wins every A/B tie.
